// File: rtl/seq_divider_if.sv
// Start/operand/result bundle for seq_divider; master drives the request,
// slave (the divider) returns results and status.
interface seq_divider_if #(
    parameter int unsigned N = 4
);
    logic           St;
    logic [2*N-1:0] Dividend;
    logic [N-1:0]   Divisor;
    logic [N-1:0]   Quotient;
    logic [N-1:0]   Remainder;
    logic           V;
    logic           Busy;
    logic           Done;

    modport master (
        output St, Dividend, Divisor,
        input  Quotient, Remainder, V, Busy, Done
    );

    modport slave (
        input  St, Dividend, Divisor,
        output Quotient, Remainder, V, Busy, Done
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit / N-bit unsigned, one quotient bit per
// cycle, with overflow/divide-by-zero detection and a Busy/Done handshake.
module seq_divider #(
    parameter int unsigned N = 4
) (
    input  logic          CLK,
    input  logic          RST,
    seq_divider_if.slave  bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N:0]     r_q, r_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           v_q, v_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [N:0]     t_c;
    logic [N:0]     diff_c;
    logic           ge_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            y_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            y_q     <= y_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        y_d     = y_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        v_d     = v_q;

        // Shift in the next dividend bit and trial-subtract the divisor
        t_c    = {r_q[N-1:0], q_q[N-1]};
        diff_c = t_c - {1'b0, y_q};
        ge_c   = (t_c >= {1'b0, y_q});

        case (state_q)
            IDLE: begin
                if (bus.St) begin
                    r_d     = {1'b0, bus.Dividend[2*N-1:N]};
                    q_d     = bus.Dividend[N-1:0];
                    y_d     = bus.Divisor;
                    v_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Upper half >= divisor means the quotient cannot fit N bits
                if ((y_q == '0) || (r_q >= {1'b0, y_q})) begin
                    v_d     = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ge_c) begin
                    r_d = diff_c;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = t_c;
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    quo_d   = q_d;
                    rem_d   = r_d[N-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.Quotient  = quo_q;
    assign bus.Remainder = rem_q;
    assign bus.V         = v_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;

endmodule
